jesd204_rx_ilas_config_capture: RTL and testbench
=================================================

Name: jesd204_rx_ilas_config_capture

Overview:
- Per-lane receive-side ILAS configuration capture for the JESD204 RX link layer, in the link clock domain.
- Watches descrambler-bypassed lane octets during the ILAS phase and extracts the 14 configuration octets from the second ILAS multiframe.
- Verifies FCHK and presents the captured 4x32-bit config words, using the same word/bit layout the TX side emits, to the RX register map and the link-parameter checker.

Parameters:
- DATA_PATH_WIDTH, 4, octets per beat; only 4 and 8 are legal; any other value is an elaboration error.

Ports:
- clk  input  1  link/core clock
- reset  input  1  synchronous active-high reset
- ilas_active  input  1  lane framer reports ILAS phase in progress
- data  input  DATA_PATH_WIDTH*8  received octets; octet n is data[n*8+:8]; octet 0 is first in time
- charisk  input  DATA_PATH_WIDTH  per-octet K-character flag
- cfg_data  output  128  captured config; word w is cfg_data[w*32+:32]
- cfg_valid  output  1  cfg_data holds a complete capture with good FCHK
- cfg_fchk_err  output  1  last complete capture had an FCHK mismatch
- cfg_k_err  output  1  last capture was aborted by a K char inside config octets
- cfg_done  output  1  one-cycle pulse when a capture completes (good or bad FCHK)

Behaviour:
- Start of capture:
  - Start condition: ilas_active=1, octet0=0x1C with charisk[0]=1 (/R/), and octet1=0x9C with charisk[1]=1 (/Q/).
  - That beat is word0 = {cfg1,cfg0,/Q/,/R/}. Word1 = cfg2..5, word2 = cfg6..9, word3 = cfg10..13. cfg13 is FCHK.
  - DPW=8 carries words {1,0} in the first beat and {3,2} in the second.
- States:
  - IDLE:
    - On the start condition, store word0 (and word1 if DPW=8).
    - Go to CAPTURE with beat counter=1.
  - CAPTURE:
    - Store one beat per cycle into the shadow buffer. The buffer is not cfg_data.
    - After the last beat (word3), go to CHECK.
    - If ilas_active=0, return to IDLE silently; outputs unchanged.
    - If any charisk bit is set in a config beat, return to IDLE and set cfg_k_err=1 for 1 cycle... correction: cfg_k_err is a sticky status; it holds until the next cfg_done or reset.
  - CHECK (one cycle):
    - Compute sum mod 256 of the raw field values (8-bit accumulation; overflow wraps): DID(o0), BID(o1[3:0]), ADJCNT(o1[7:4]), LID(o2[4:0]), PHADJ(o2[5]), ADJDIR(o2[6]), L(o3[4:0]), SCR(o3[7]), F(o4), K(o5[4:0]), M(o6), N(o7[4:0]), CS(o7[7:6]), N'(o8[4:0]), SUBCLASSV(o8[7:5]), S(o9[4:0]), JESDV(o9[7:5]), CF(o10[4:0]), HD(o10[7]). Here on = cfg octet n.
    - On the clock edge ending CHECK:
      - Copy the shadow buffer to cfg_data. Word0 bits[15:0] are forced to 0.
      - cfg_done=1 for 1 cycle.
      - cfg_fchk_err = (sum != cfg13).
      - cfg_valid = (sum == cfg13).
      - cfg_k_err=0.
      - Return to IDLE.
- Latency:
  - Relative to the /R//Q/ beat at cycle T, outputs update in cycle T+5 for DPW=4 and T+3 for DPW=8.
  - During CAPTURE/CHECK, cfg_* keep their previous values.
- Repeated ILAS (continuous ILAS, or a link restart without reset):
  - Each new /R//Q/ beat in IDLE starts a new capture.
  - cfg_valid stays at its old value until the new capture completes, then takes the new result.
- A start condition during CAPTURE is treated as ordinary data. There is no resync; the capture ends normally or by K-abort.
- Start condition with ilas_active=0: ignored.
- Reset:
  - Returns to IDLE from any state, including mid-capture.
  - Clears cfg_data=0, cfg_valid=0, cfg_fchk_err=0, cfg_k_err=0, cfg_done=0, the shadow buffer, and the beat counter.

Test Plan:
- Good ILAS, DPW=4:
  - Stimulus: /R//Q/ beat, then cfg DID=0x5A, BID=3, LID=2, L=3, SCR=1, F=1, K=31, M=3, N=15, CS=0, N'=15, SUBCLASSV=1, S=0, JESDV=1, CF=0, HD=0, with FCHK = correct sum.
  - Expected: cfg_done pulse at T+5; cfg_valid=1; cfg_fchk_err=0; cfg_data word1=0x1F018302; word0 bits[15:0]=0.
- Same data with FCHK+1 -> cfg_valid=0, cfg_fchk_err=1, cfg_data still updated, cfg_done pulse.
- K char (charisk=0b0100) in word2 -> no cfg_done, cfg_k_err=1, cfg_valid unchanged.
  - A following clean capture clears cfg_k_err and sets cfg_valid=1.
- ilas_active dropped after word1 -> return to IDLE, no cfg_done, all outputs unchanged.
  - reset asserted mid-CAPTURE -> all outputs 0 the next cycle.
  - /R//Q/ with ilas_active=0 -> ignored.
- DPW=8, same config as test 1 -> cfg_done at T+3 with identical cfg_data.
  - Two back-to-back ILAS with different DID -> cfg_data reflects the second DID after the second cfg_done.
- FCHK wrap:
  - Stimulus: F=0xFF, M=0xFF, DID=0xFF, FCHK=(sum mod 256).
  - Expected: cfg_valid=1, confirming 8-bit wraparound.

Source files
------------

// File: rtl/jesd204_rx_ilas_config_capture.sv
// rtl/jesd204_rx_ilas_config_capture.sv - JESD204 RX per-lane ILAS config octet capture with FCHK check
// Captures the second ILAS multiframe config octets, checks FCHK and publishes the 4x32 config words.
module jesd204_rx_ilas_config_capture #(
   parameter int DATA_PATH_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ilas_active,
   input  logic [DATA_PATH_WIDTH*8-1:0] data,
   input  logic [DATA_PATH_WIDTH-1:0]   charisk,
   output logic [127:0]                 cfg_data,
   output logic                         cfg_valid,
   output logic                         cfg_fchk_err,
   output logic                         cfg_k_err,
   output logic                         cfg_done
);

   localparam int W    = DATA_PATH_WIDTH * 8;
   localparam int LAST = (128 / W) - 1;

   if (DATA_PATH_WIDTH != 4 && DATA_PATH_WIDTH != 8) begin : g_bad_dpw
      $error("DATA_PATH_WIDTH must be 4 or 8");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_CHECK
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [1:0]     r_cnt;
   // The /R//Q/ octets are never stored; cfg_data bits [15:0] read back as 0.
   logic [127:16]  r_shadow;
   logic [127:0]   r_cfg_data;
   logic           r_cfg_valid;
   logic           r_cfg_fchk_err;
   logic           r_cfg_k_err;
   logic           r_cfg_done;

   logic           w_start;
   logic           w_store_first;
   logic           w_store_beat;
   logic           w_abort_k;
   logic           w_finish;
   logic [7:0]     w_sum;

   assign w_start = ilas_active
                  && (data[7:0]  == 8'h1C) && charisk[0]
                  && (data[15:8] == 8'h9C) && charisk[1];

   always_comb begin
      w_state_nxt   = r_state;
      w_store_first = 1'b0;
      w_store_beat  = 1'b0;
      w_abort_k     = 1'b0;
      w_finish      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_store_first = 1'b1;
               w_state_nxt   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (!ilas_active) begin
               w_state_nxt = S_IDLE;
            end else if (|charisk) begin
               w_abort_k   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_store_beat = 1'b1;
               if (r_cnt == 2'(LAST)) begin
                  w_state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FCHK: 8-bit wrapping sum of the raw link-parameter fields in octets 0..10.
   assign w_sum = r_shadow[23:16]
                + {4'h0, r_shadow[27:24]}  + {4'h0, r_shadow[31:28]}
                + {3'h0, r_shadow[36:32]}  + {7'h0, r_shadow[37]}
                + {7'h0, r_shadow[38]}     + {3'h0, r_shadow[44:40]}
                + {7'h0, r_shadow[47]}     + r_shadow[55:48]
                + {3'h0, r_shadow[60:56]}  + r_shadow[71:64]
                + {3'h0, r_shadow[76:72]}  + {6'h0, r_shadow[79:78]}
                + {3'h0, r_shadow[84:80]}  + {5'h0, r_shadow[87:85]}
                + {3'h0, r_shadow[92:88]}  + {5'h0, r_shadow[95:93]}
                + {3'h0, r_shadow[100:96]} + {7'h0, r_shadow[103]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= 2'd0;
         r_shadow       <= '0;
         r_cfg_data     <= '0;
         r_cfg_valid    <= 1'b0;
         r_cfg_fchk_err <= 1'b0;
         r_cfg_k_err    <= 1'b0;
         r_cfg_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cfg_done <= 1'b0;
         if (w_store_first) begin
            r_shadow[W-1:16] <= data[W-1:16];
            r_cnt            <= 2'd1;
         end
         if (w_store_beat) begin
            r_shadow[int'(r_cnt)*W +: W] <= data;
            r_cnt                        <= r_cnt + 2'd1;
         end
         if (w_abort_k) begin
            r_cfg_k_err <= 1'b1;
         end
         if (w_finish) begin
            r_cfg_data     <= {r_shadow, 16'h0000};
            r_cfg_done     <= 1'b1;
            r_cfg_fchk_err <= (w_sum != r_shadow[127:120]);
            r_cfg_valid    <= (w_sum == r_shadow[127:120]);
            r_cfg_k_err    <= 1'b0;
         end
      end
   end

   assign cfg_data     = r_cfg_data;
   assign cfg_valid    = r_cfg_valid;
   assign cfg_fchk_err = r_cfg_fchk_err;
   assign cfg_k_err    = r_cfg_k_err;
   assign cfg_done     = r_cfg_done;

endmodule

// File: tb/tb_jesd204_rx_ilas_config_capture.sv
// tb/tb_jesd204_rx_ilas_config_capture.sv - directed bench for the ILAS config capture, DPW=4 and DPW=8
module tb_jesd204_rx_ilas_config_capture;

   logic          clk = 1'b0;
   logic          reset;
   logic          ilas;
   logic [31:0]   d4;
   logic [3:0]    k4;
   logic [63:0]   d8;
   logic [7:0]    k8;
   logic [127:0]  cd4, cd8;
   logic          v4, fe4, ke4, dn4;
   logic          v8, fe8, ke8, dn8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   jesd204_rx_ilas_config_capture #(.DATA_PATH_WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .ilas_active(ilas), .data(d4), .charisk(k4),
      .cfg_data(cd4), .cfg_valid(v4), .cfg_fchk_err(fe4), .cfg_k_err(ke4), .cfg_done(dn4)
   );

   jesd204_rx_ilas_config_capture #(.DATA_PATH_WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .ilas_active(ilas), .data(d8), .charisk(k8),
      .cfg_data(cd8), .cfg_valid(v8), .cfg_fchk_err(fe8), .cfg_k_err(ke8), .cfg_done(dn8)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Octets 0..13 = DID, 0x03, 0x02, 0x83, F, 0x1F, M, 0x0F, 0x2F, 0x20, 0, 0, 0, FCHK
   function automatic logic [127:0] mk(input logic [7:0] did, input logic [7:0] f,
                                       input logic [7:0] m, input logic [7:0] fchk);
      return {fchk, 8'h00, 8'h00, 8'h00, 8'h20, 8'h2F, 8'h0F, m,
              8'h1F, f, 8'h83, 8'h02, 8'h03, did, 8'h9C, 8'h1C};
   endfunction

   task automatic expect4(input string t, input logic [127:0] data, input logic valid,
                          input logic fe, input logic ke, input logic done);
      check({t, ".data"}, cd4, data);
      check({t, ".valid"}, {127'd0, v4}, {127'd0, valid});
      check({t, ".fchk_err"}, {127'd0, fe4}, {127'd0, fe});
      check({t, ".k_err"}, {127'd0, ke4}, {127'd0, ke});
      check({t, ".done"}, {127'd0, dn4}, {127'd0, done});
   endtask

   task automatic expect8(input string t, input logic [127:0] data, input logic valid,
                          input logic fe, input logic ke, input logic done);
      check({t, ".data8"}, cd8, data);
      check({t, ".valid8"}, {127'd0, v8}, {127'd0, valid});
      check({t, ".fchk_err8"}, {127'd0, fe8}, {127'd0, fe});
      check({t, ".k_err8"}, {127'd0, ke8}, {127'd0, ke});
      check({t, ".done8"}, {127'd0, dn8}, {127'd0, done});
   endtask

   // Four DPW=4 beats; ilas_m[b] is ilas_active for beat b; kmask is applied on beat kbeat.
   task automatic run4(input string t, input logic [127:0] v, input int kbeat,
                       input logic [3:0] kmask, input logic [3:0] ilas_m);
      for (int b = 0; b < 4; b++) begin
         ilas = ilas_m[b];
         d4   = v[b*32 +: 32];
         k4   = (b == 0) ? 4'b0011 : ((b == kbeat) ? kmask : 4'b0000);
         tick;
         check({t, ".busy_done"}, {127'd0, dn4}, 128'd0);
      end
      ilas = 1'b0;
      d4   = '0;
      k4   = '0;
   endtask

   task automatic run8(input string t, input logic [127:0] v);
      ilas = 1'b1;
      d8   = v[63:0];
      k8   = 8'h03;
      tick;
      check({t, ".busy_done8"}, {127'd0, dn8}, 128'd0);
      d8 = v[127:64];
      k8 = 8'h00;
      tick;
      check({t, ".busy_done8"}, {127'd0, dn8}, 128'd0);
      ilas = 1'b0;
      d8   = '0;
   endtask

   logic [127:0] v1, v2, v11, v22, vw, e1;

   initial begin
      v1  = mk(8'h5A, 8'h01, 8'h03, 8'hA6);
      v2  = mk(8'h5A, 8'h01, 8'h03, 8'hA7);
      v11 = mk(8'h11, 8'h01, 8'h03, 8'h5D);
      v22 = mk(8'h22, 8'h01, 8'h03, 8'h6E);
      vw  = mk(8'hFF, 8'hFF, 8'hFF, 8'h45);
      e1  = {32'hA6000000, 32'h202F0F03, 32'h1F018302, 32'h035A0000};

      reset = 1'b1; ilas = 1'b0; d4 = '0; k4 = '0; d8 = '0; k8 = '0;
      tick; tick;
      expect4("reset", 128'd0, 0, 0, 0, 0);
      expect8("reset", 128'd0, 0, 0, 0, 0);
      reset = 1'b0;
      tick;

      // Good capture: done at T+5
      run4("good", v1, -1, 4'b0000, 4'b1111);
      tick;
      expect4("good", e1, 1, 0, 0, 1);
      check("good.word1", {96'd0, cd4[63:32]}, {96'd0, 32'h1F018302});
      check("good.word0_lo", {112'd0, cd4[15:0]}, 128'd0);
      tick;
      check("good.pulse", {127'd0, dn4}, 128'd0);

      // Bad FCHK: valid holds until done, then drops
      run4("fchk", v2, -1, 4'b0000, 4'b1111);
      check("fchk.hold_valid", {127'd0, v4}, 128'd1);
      tick;
      expect4("fchk", {v2[127:16], 16'h0000}, 0, 1, 0, 1);

      // Good, then K abort in word2
      run4("good2", v1, -1, 4'b0000, 4'b1111);
      tick;
      expect4("good2", e1, 1, 0, 0, 1);
      run4("kerr", v11, 2, 4'b0100, 4'b1111);
      tick; tick;
      expect4("kerr", e1, 1, 0, 1, 0);
      run4("kclr", v1, -1, 4'b0000, 4'b1111);
      check("kclr.k_hold", {127'd0, ke4}, 128'd1);
      tick;
      expect4("kclr", e1, 1, 0, 0, 1);

      // ilas_active dropped after word1
      run4("drop", v11, -1, 4'b0000, 4'b0011);
      tick; tick;
      expect4("drop", e1, 1, 0, 0, 0);

      // /R//Q/ with ilas_active=0 is not a start
      run4("noilas", v11, -1, 4'b0000, 4'b1110);
      tick; tick;
      expect4("noilas", e1, 1, 0, 0, 0);

      // Reset mid-capture
      ilas = 1'b1; d4 = v11[31:0]; k4 = 4'b0011;
      tick;
      d4 = v11[63:32]; k4 = 4'b0000;
      tick;
      reset = 1'b1;
      tick;
      expect4("midrst", 128'd0, 0, 0, 0, 0);
      reset = 1'b0; ilas = 1'b0; d4 = '0;
      tick;
      run4("postrst", v1, -1, 4'b0000, 4'b1111);
      tick;
      expect4("postrst", e1, 1, 0, 0, 1);

      // DPW=8: done at T+3
      run8("dpw8", v1);
      tick;
      expect8("dpw8", e1, 1, 0, 0, 1);
      tick;
      check("dpw8.pulse", {127'd0, dn8}, 128'd0);

      // Back-to-back ILAS, second DID wins
      run8("b2b_a", v22);
      tick;
      expect8("b2b_a", {v22[127:16], 16'h0000}, 1, 0, 0, 1);
      run8("b2b_b", v11);
      tick;
      expect8("b2b_b", {v11[127:16], 16'h0000}, 1, 0, 0, 1);
      check("b2b_b.word0", {96'd0, cd8[31:0]}, {96'd0, 32'h03110000});

      // FCHK 8-bit wraparound
      run4("wrap", vw, -1, 4'b0000, 4'b1111);
      tick;
      expect4("wrap", {vw[127:16], 16'h0000}, 1, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
